wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter N, default 32: data width of every register and data port.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  synchronous, active-high reset, sampled on rising edge of CLK.
REQ-004 ReadData_i  input  N  memory load data from MEM/WB pipeline register.
REQ-005 AluResult_i  input  N  ALU result from MEM/WB pipeline register.
REQ-006 WBSelect_i  input  1  writeback source: 1 = ReadData_i, 0 = AluResult_i.
REQ-007 RF_WE_i  input  1  register-file write enable from MEM/WB.
REQ-008 A3_i  input  4  destination register index from MEM/WB.
REQ-009 A1_i  input  4  read port 1 index, from decode stage.
REQ-010 A2_i  input  4  read port 2 index, from decode stage.
REQ-011 PCPlus8_i  input  N  current fetch PC + 8; value returned for reads of R15.
REQ-012 RD1_o  output  N  read port 1 data.
REQ-013 RD2_o  output  N  read port 2 data.
REQ-014 Result_o  output  N  selected writeback value, for forwarding into execute.
REQ-015 WBValid_o  output  1  high when a real register write (R0..R14) occurs this cycle.
REQ-016 WriteCount_o  output  16  count of committed register writes since reset.

Function
REQ-017 Storage: 15 registers R0..R14, N bits each; R15 is not stored.
REQ-018 Result_o = WBSelect_i ? ReadData_i : AluResult_i. Combinational, zero latency.
REQ-019 Commit: on a rising edge with RST=0, RF_WE_i=1 and A3_i != 15, the block writes Result_o into R[A3_i].
REQ-020 Writes with A3_i = 15 are discarded: no register changes and WriteCount_o does not increment.
REQ-021 WBValid_o = RF_WE_i & (A3_i != 15) & ~RST. Combinational.
REQ-022 Read ports are combinational. RDx_o = PCPlus8_i when Ax_i = 15, otherwise R[Ax_i].
REQ-023 Internal bypass (write-first): when WBValid_o=1 and Ax_i = A3_i, RDx_o = Result_o in the same cycle, before the edge commits the write.
REQ-024 The bypass never applies to index 15; the R15 rule of REQ-022 always wins.
REQ-025 Both read ports may address the same register or the write target simultaneously; each port resolves independently with identical results.
REQ-026 WriteCount_o increments by 1 on each edge where a commit per REQ-019 occurs.
REQ-027 WriteCount_o wraps from 16'hFFFF to 16'h0000 with no flag.
REQ-028 Register contents persist indefinitely while RF_WE_i=0; there is no stall or enable input.
REQ-029 X-free: no output depends on an uninitialised register after the first reset cycle.

Reset
REQ-030 On an edge with RST=1, R0..R14 clear to 0 and WriteCount_o clears to 0.
REQ-031 During a reset cycle, any concurrent write is suppressed, WBValid_o=0 and the bypass is disabled.
REQ-032 During reset, RDx_o returns 0 for indices 0..14 after the reset edge and PCPlus8_i for index 15; Result_o continues to follow REQ-018.
REQ-033 Reset asserted mid-stream discards the in-flight write in that cycle; the next write after RST deasserts commits normally.

Verification
REQ-034 Reset, then A1_i=3, A2_i=15, PCPlus8_i=0x108 -> RD1_o=0, RD2_o=0x108, WriteCount_o=0.
REQ-035 RF_WE_i=1, A3_i=5, WBSelect_i=0, AluResult_i=0xDEADBEEF, A1_i=5 in the same cycle -> RD1_o=0xDEADBEEF before the edge (bypass); after the edge, with RF_WE_i=0, RD1_o=0xDEADBEEF and WriteCount_o=1.
REQ-036 RF_WE_i=1, A3_i=15, ReadData_i=0x1234, WBSelect_i=1 -> WBValid_o=0, Result_o=0x1234, no register changes, WriteCount_o unchanged, and A1_i=15 returns PCPlus8_i.
REQ-037 Write 0xA to R2 with RST=1 in the same cycle -> R2 reads 0 afterwards and WriteCount_o=0; repeat with RST=0 -> R2=0xA and WriteCount_o=1.
REQ-038 Issue 65536 back-to-back commits to R1..R14 -> WriteCount_o returns to 0x0000, and the last value written to each register reads back correctly on both ports.
REQ-039 A1_i=A2_i=A3_i=7, RF_WE_i=1, load-select with ReadData_i=0x55 -> RD1_o=RD2_o=0x55 in the same cycle, and R7=0x55 after the edge.

Source files
------------

// File: rtl/wb_regfile.sv
// Writeback stage and 15-entry register file with R15 mapped to PC+8.
// Ports: CLK/RST (sync, active-high); ReadData_i/AluResult_i/WBSelect_i
// choose the writeback value; RF_WE_i/A3_i commit it; A1_i/A2_i read
// ports RD1_o/RD2_o; Result_o forwards the writeback value;
// WBValid_o flags a real write; WriteCount_o counts commits.
module wb_regfile #(
    parameter int N = 32
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [N-1:0] ReadData_i,
    input  logic [N-1:0] AluResult_i,
    input  logic         WBSelect_i,
    input  logic         RF_WE_i,
    input  logic [3:0]   A3_i,
    input  logic [3:0]   A1_i,
    input  logic [3:0]   A2_i,
    input  logic [N-1:0] PCPlus8_i,
    output logic [N-1:0] RD1_o,
    output logic [N-1:0] RD2_o,
    output logic [N-1:0] Result_o,
    output logic         WBValid_o,
    output logic [15:0]  WriteCount_o
);

    localparam logic [3:0] PC_IDX = 4'd15;

    logic [N-1:0] regs_q [15];
    logic [15:0]  cnt_q;
    logic [15:0]  cnt_d;

    assign Result_o  = WBSelect_i ? ReadData_i : AluResult_i;
    assign WBValid_o = RF_WE_i & (A3_i != PC_IDX) & ~RST;
    assign cnt_d     = cnt_q + 16'd1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 15; i++) begin
                regs_q[i] <= '0;
            end
            cnt_q <= '0;
        end else if (WBValid_o) begin
            for (int i = 0; i < 15; i++) begin
                if (A3_i == 4'(i)) begin
                    regs_q[i] <= Result_o;
                end
            end
            cnt_q <= cnt_d;
        end
    end

    // R15 beats the bypass; the bypass beats stored contents so a
    // decode-stage read sees the value being written this cycle.
    always_comb begin
        RD1_o = '0;
        if (A1_i == PC_IDX) begin
            RD1_o = PCPlus8_i;
        end else if (WBValid_o && (A1_i == A3_i)) begin
            RD1_o = Result_o;
        end else begin
            for (int i = 0; i < 15; i++) begin
                if (A1_i == 4'(i)) begin
                    RD1_o = regs_q[i];
                end
            end
        end
    end

    always_comb begin
        RD2_o = '0;
        if (A2_i == PC_IDX) begin
            RD2_o = PCPlus8_i;
        end else if (WBValid_o && (A2_i == A3_i)) begin
            RD2_o = Result_o;
        end else begin
            for (int i = 0; i < 15; i++) begin
                if (A2_i == 4'(i)) begin
                    RD2_o = regs_q[i];
                end
            end
        end
    end

    assign WriteCount_o = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed table, random run
// against a reference model, and a 65536-commit counter wrap sequence.
module tb_wb_regfile;

    localparam int N = 32;

    logic         CLK = 1'b0;
    logic         RST;
    logic [N-1:0] ReadData_i;
    logic [N-1:0] AluResult_i;
    logic         WBSelect_i;
    logic         RF_WE_i;
    logic [3:0]   A3_i;
    logic [3:0]   A1_i;
    logic [3:0]   A2_i;
    logic [N-1:0] PCPlus8_i;
    logic [N-1:0] RD1_o;
    logic [N-1:0] RD2_o;
    logic [N-1:0] Result_o;
    logic         WBValid_o;
    logic [15:0]  WriteCount_o;

    wb_regfile #(.N(N)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ReadData_i  (ReadData_i),
        .AluResult_i (AluResult_i),
        .WBSelect_i  (WBSelect_i),
        .RF_WE_i     (RF_WE_i),
        .A3_i        (A3_i),
        .A1_i        (A1_i),
        .A2_i        (A2_i),
        .PCPlus8_i   (PCPlus8_i),
        .RD1_o       (RD1_o),
        .RD2_o       (RD2_o),
        .Result_o    (Result_o),
        .WBValid_o   (WBValid_o),
        .WriteCount_o(WriteCount_o)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        we;
        logic        sel;
        logic [3:0]  a3;
        logic [3:0]  a1;
        logic [3:0]  a2;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic [31:0] e_res;
        logic        e_valid;
        logic [15:0] e_cnt;
    } vec_t;

    int checks = 0;
    int failures = 0;

    // Reference state: architectural registers and commit count.
    logic [31:0] m_reg [15];
    int unsigned m_cnt;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic we, input logic sel,
                         input logic [3:0] a3, input logic [3:0] a1,
                         input logic [3:0] a2, input logic [31:0] rdata,
                         input logic [31:0] alu, input logic [31:0] pc);
        RST = rst; RF_WE_i = we; WBSelect_i = sel;
        A3_i = a3; A1_i = a1; A2_i = a2;
        ReadData_i = rdata; AluResult_i = alu; PCPlus8_i = pc;
    endtask

    function automatic logic [31:0] m_read(input logic [3:0] a);
        logic [31:0] res;
        logic        wr;
        res = WBSelect_i ? ReadData_i : AluResult_i;
        wr  = RF_WE_i && (A3_i != 4'd15) && !RST;
        if (a == 4'd15) return PCPlus8_i;
        if (wr && a == A3_i) return res;
        return m_reg[a];
    endfunction

    task automatic m_commit();
        if (RST) begin
            for (int i = 0; i < 15; i++) m_reg[i] = '0;
            m_cnt = 0;
        end else if (RF_WE_i && A3_i != 4'd15) begin
            m_reg[A3_i] = WBSelect_i ? ReadData_i : AluResult_i;
            m_cnt = (m_cnt + 1) % 65536;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    vec_t tbl [12];
    logic [31:0] last [15];

    initial begin
        tbl[0]  = '{1,0,0, 0, 3,15, 0,0,32'h108, 0,32'h108,0,0,0};
        tbl[1]  = '{0,1,0, 5, 5, 0, 0,32'hDEADBEEF,32'h10,
                    32'hDEADBEEF,0,32'hDEADBEEF,1,0};
        tbl[2]  = '{0,0,0, 0, 5, 5, 0,0,32'h10,
                    32'hDEADBEEF,32'hDEADBEEF,0,0,1};
        tbl[3]  = '{0,1,1,15,15, 5,32'h1234,0,32'h200,
                    32'h200,32'hDEADBEEF,32'h1234,0,1};
        tbl[4]  = '{0,0,0, 0, 5,15, 0,0,32'h300,
                    32'hDEADBEEF,32'h300,0,0,1};
        tbl[5]  = '{1,1,0, 2, 2, 2, 0,32'hA,32'h10, 0,0,32'hA,0,1};
        tbl[6]  = '{0,0,0, 0, 2, 5, 0,0,32'h10, 0,0,0,0,0};
        tbl[7]  = '{0,1,0, 2, 2, 3, 0,32'hA,32'h10, 32'hA,0,32'hA,1,0};
        tbl[8]  = '{0,0,0, 0, 2, 2, 0,0,32'h10, 32'hA,32'hA,0,0,1};
        tbl[9]  = '{0,1,1, 7, 7, 7,32'h55,32'h99,32'h10,
                    32'h55,32'h55,32'h55,1,1};
        tbl[10] = '{0,0,0, 0, 7, 2, 0,0,32'h10, 32'h55,32'hA,0,0,2};
        tbl[11] = '{0,1,0,15,15,15, 0,32'h77,32'h444,
                    32'h444,32'h444,32'h77,0,2};

        drive(1,0,0,0,0,0,0,0,0);
        tick();
        tick();

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].rst, tbl[i].we, tbl[i].sel, tbl[i].a3,
                  tbl[i].a1, tbl[i].a2, tbl[i].rdata, tbl[i].alu,
                  tbl[i].pc);
            @(negedge CLK);
            chk($sformatf("tbl%0d_rd1", i), RD1_o, tbl[i].e_rd1);
            chk($sformatf("tbl%0d_rd2", i), RD2_o, tbl[i].e_rd2);
            chk($sformatf("tbl%0d_res", i), Result_o, tbl[i].e_res);
            chk($sformatf("tbl%0d_valid", i), 32'(WBValid_o),
                32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_cnt", i), 32'(WriteCount_o),
                32'(tbl[i].e_cnt));
            tick();
        end

        // Random run against the model, starting from a fresh reset.
        drive(1,0,0,0,0,0,0,0,0);
        for (int i = 0; i < 15; i++) m_reg[i] = 'x;
        m_cnt = 0;
        m_commit();
        tick();
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 49) == 0), $urandom_range(0, 1),
                  $urandom_range(0, 1), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  $urandom, $urandom, $urandom);
            @(negedge CLK);
            chk("rnd_rd1", RD1_o, m_read(A1_i));
            chk("rnd_rd2", RD2_o, m_read(A2_i));
            chk("rnd_res", Result_o, WBSelect_i ? ReadData_i : AluResult_i);
            chk("rnd_valid", 32'(WBValid_o),
                32'(RF_WE_i && A3_i != 4'd15 && !RST));
            chk("rnd_cnt", 32'(WriteCount_o), m_cnt);
            m_commit();
            tick();
        end

        // 65536 back-to-back commits wrap the counter to zero.
        drive(1,0,0,0,0,0,0,0,0);
        tick();
        for (int i = 0; i < 15; i++) last[i] = '0;
        for (int i = 0; i < 65536; i++) begin
            logic [3:0]  a;
            logic [31:0] d;
            a = 4'($urandom_range(1, 14));
            d = $urandom;
            last[a] = d;
            drive(0,1,0,a,0,0,0,d,0);
            tick();
        end
        drive(0,0,0,0,0,0,0,0,32'hFEED);
        @(negedge CLK);
        chk("wrap_cnt", 32'(WriteCount_o), 0);
        for (int r = 1; r < 15; r++) begin
            A1_i = 4'(r);
            A2_i = 4'(r);
            #1;
            chk($sformatf("wrap_r%0d_p1", r), RD1_o, last[r]);
            chk($sformatf("wrap_r%0d_p2", r), RD2_o, last[r]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
